// File: rtl/comm_pkg.sv
// Shared definitions for the host command sender and the robot-side command processor.
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
package comm_pkg;

    // Sender FSM: one cycle to launch the high byte, then wait for each byte to finish
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TX_HI   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } rc_state_t;

    // Response window in clock cycles (100 ms at 50 MHz)
    localparam int unsigned RESP_TMO_DEF = 32'd5_000_000;

    // Clocks per UART bit (19200 baud at 50 MHz)
    localparam int BAUD_DIV_DEF = 2604;

    // Command opcodes occupy cmd[15:12]; the receiver decodes the same values
    localparam logic [3:0] OPC_CAL  = 4'b0010;
    localparam logic [3:0] OPC_HDG  = 4'b0011;
    localparam logic [3:0] OPC_BATT = 4'b0100;
    localparam logic [3:0] OPC_STOP = 4'b0101;

    // Build a command word from an opcode and its 12-bit argument
    function automatic logic [15:0] mk_cmd(input logic [3:0] opc, input logic [11:0] arg);
        return {opc, arg};
    endfunction

endpackage

// File: rtl/UART.sv
// 8N1 UART transceiver: one byte per trmt on TX, one byte per frame captured from RX.
// Latency: tx_done 10*BAUD_DIV cycles after trmt; rx_rdy ~2 sync cycles after mid stop bit.
// Backpressure: none; trmt while busy restarts the frame, rx_rdy holds until clr_rx_rdy.
module UART import comm_pkg::*; #(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy,
    output logic [7:0] rx_data,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);

    logic [9:0]    tx_shft;
    logic [CW-1:0] tx_baud;
    logic [3:0]    tx_bits;
    logic          tx_busy;

    logic [1:0]    rx_sync;
    logic          rx_busy;
    logic [CW-1:0] rx_baud;
    logic [3:0]    rx_bits;
    logic [8:0]    rx_shft;

    // Line is the LSB of the shift register, which resets to all ones so TX idles high
    assign TX = tx_shft[0];

    // Transmitter: load start/data/stop on trmt, shift one bit per baud period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shft <= '1;
            tx_baud <= '0;
            tx_bits <= '0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else if (trmt) begin
            tx_shft <= {1'b1, tx_data, 1'b0};
            tx_baud <= '0;
            tx_bits <= '0;
            tx_busy <= 1'b1;
            tx_done <= 1'b0;
        end else if (tx_busy) begin
            if (tx_baud == BAUD_LAST) begin
                tx_baud <= '0;
                tx_shft <= {1'b1, tx_shft[9:1]};
                tx_bits <= tx_bits + 4'd1;
                if (tx_bits == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end
            end else begin
                tx_baud <= tx_baud + 1'b1;
            end
        end
    end

    // Two-flop synchronizer on the asynchronous RX line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], RX};
    end

    // Receiver: detect start edge, sample mid-bit, publish the byte on the stop-bit sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy <= 1'b0;
            rx_baud <= '0;
            rx_bits <= '0;
            rx_shft <= '0;
            rx_data <= '0;
            rx_rdy  <= 1'b0;
        end else begin
            if (clr_rx_rdy) rx_rdy <= 1'b0;
            if (!rx_busy) begin
                if (!rx_sync[1]) begin
                    rx_busy <= 1'b1;
                    rx_baud <= BAUD_HALF;
                    rx_bits <= '0;
                end
            end else if (rx_baud == BAUD_LAST) begin
                rx_baud <= '0;
                rx_bits <= rx_bits + 4'd1;
                rx_shft <= {rx_sync[1], rx_shft[8:1]};
                if (rx_bits == 4'd9) begin
                    rx_busy <= 1'b0;
                    rx_data <= rx_shft[8:1];
                    rx_rdy  <= 1'b1;
                end
            end else begin
                rx_baud <= rx_baud + 1'b1;
            end
        end
    end

endmodule

// File: rtl/remote_comm.sv
// Host command sender: 16-bit cmd out as two UART bytes (high first), 1-byte response in.
// Latency: cmd_snt 2*(10*BAUD_DIV)+3 cycles after snd_cmd is accepted.
// Backpressure: snd_cmd only honoured in IDLE (busy=0); requests while busy are dropped.
module remote_comm import comm_pkg::*; #(
    parameter int unsigned RESP_TMO = RESP_TMO_DEF,
    parameter int          BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic        snd_cmd,
    input  logic [15:0] cmd,
    input  logic        clr_resp_rdy,
    output logic        cmd_snt,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        resp_tmo,
    output logic        busy
);

    localparam int TMO_W = (RESP_TMO > 2) ? $clog2(RESP_TMO) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TMO - 1);

    rc_state_t        state;
    logic [15:0]      hold;
    logic [TMO_W-1:0] tmo_cnt;
    logic             trmt;
    logic [7:0]       tx_data;
    logic             tx_done;
    logic             rx_rdy;
    logic             clr_rx_rdy;
    logic [7:0]       rx_data;
    logic             accept;
    logic             lo_done;

    assign accept     = (state == IDLE) && snd_cmd;
    assign lo_done    = (state == WAIT_LO) && tx_done;
    assign clr_rx_rdy = rx_rdy;

    // Launch the high byte from TX_HI; chain the low byte on the cycle the high byte completes
    always_comb begin
        trmt    = 1'b0;
        tx_data = hold[15:8];
        case (state)
            TX_HI:   trmt = 1'b1;
            WAIT_HI: begin
                trmt    = tx_done;
                tx_data = hold[7:0];
            end
            default: trmt = 1'b0;
        endcase
    end

    // Command FSM with its registered busy/cmd_snt flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            hold    <= '0;
            busy    <= 1'b0;
            cmd_snt <= 1'b0;
        end else begin
            case (state)
                IDLE: if (snd_cmd) begin
                    hold    <= cmd;
                    busy    <= 1'b1;
                    cmd_snt <= 1'b0;
                    state   <= TX_HI;
                end
                TX_HI:   state <= WAIT_HI;
                WAIT_HI: if (tx_done) state <= WAIT_LO;
                WAIT_LO: if (tx_done) begin
                    busy    <= 1'b0;
                    cmd_snt <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Capture each received byte; a new byte beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp     <= '0;
            resp_rdy <= 1'b0;
        end else if (rx_rdy) begin
            resp     <= rx_data;
            resp_rdy <= 1'b1;
        end else if (clr_resp_rdy || accept) begin
            resp_rdy <= 1'b0;
        end
    end

    // Response timeout: count from cmd_snt until a byte arrives or the window expires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt  <= '0;
            resp_tmo <= 1'b0;
        end else begin
            if (lo_done) begin
                tmo_cnt <= '0;
            end else if (cmd_snt && !resp_rdy && !resp_tmo) begin
                if (tmo_cnt == TMO_LAST) resp_tmo <= 1'b1;
                else                     tmo_cnt  <= tmo_cnt + 1'b1;
            end
            if (accept) resp_tmo <= 1'b0;
        end
    end

    UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (clr_rx_rdy),
        .rx_data    (rx_data),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done)
    );

endmodule

// File: doc/remote_comm.md
# remote_comm

Host-side command sender that sits directly upstream of the robot's UART command receiver. It accepts a 16-bit command in one cycle and serializes it as two UART frames, high byte first, which is the framing the receiver reassembles into `cmd`. It also captures the single-byte response returned over RX and flags a response timeout. Used in full-chip testbenches and as the remote/host model.

## Interface
- `RESP_TMO`, default 32'd5_000_000: clock cycles allowed between `cmd_snt` rising and a response byte arriving before `resp_tmo` sets.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `RX` in 1: serial input carrying response bytes.
- `TX` out 1: serial output carrying command bytes. Idles high.
- `snd_cmd` in 1: single-cycle request to send `cmd`. Honoured only in IDLE.
- `cmd` in 16: command word, sampled on the cycle `snd_cmd` is accepted.
- `clr_resp_rdy` in 1: clears `resp_rdy`.
- `cmd_snt` out 1: both bytes have been transmitted. Sticky.
- `resp` out 8: last response byte received.
- `resp_rdy` out 1: a new response byte is held in `resp`.
- `resp_tmo` out 1: no response arrived within `RESP_TMO` cycles of `cmd_snt`.
- `busy` out 1: FSM is not in IDLE.

## Operation
- **Reset values:** all outputs are 0, except `TX`, which is 1. FSM = IDLE, the hold register = 0, the timeout counter = 0.
- **FSM states:** IDLE, TX_HI, WAIT_HI, WAIT_LO.
  - IDLE: if `snd_cmd`, load `cmd` into the 16-bit hold register and go to TX_HI. Otherwise stay.
  - TX_HI: drive `trmt`=1 and `tx_data`=hold[15:8] for exactly one cycle, then go to WAIT_HI.
  - WAIT_HI: when the UART `tx_done` is seen, drive `trmt`=1 and `tx_data`=hold[7:0] in that same cycle, then go to WAIT_LO.
  - WAIT_LO: when `tx_done` is seen, set `cmd_snt`, clear and start the timeout counter, and go to IDLE.
- **`tx_done` handling:** `tx_done` is level-sensitive and is cleared by the UART on `trmt`. It is therefore only qualified in the WAIT states, which are always entered on the edge that issued `trmt`.
- **`snd_cmd` while busy:** ignored. It does not alter the hold register, `cmd` is not re-sampled, and `snd_cmd` is not queued.
- **`cmd_snt`:** SR flop.
  - Set in WAIT_LO when `tx_done` is seen.
  - Cleared when `snd_cmd` is accepted in IDLE.
- **Response capture:**
  - When the UART `rx_rdy` is high, load `rx_data` into `resp`, set `resp_rdy`, and pulse `clr_rx_rdy` in the same cycle.
  - `resp_rdy` is cleared by `clr_resp_rdy` or by an accepted `snd_cmd`.
  - Set wins over clear when they coincide.
- **Timeout:**
  - The counter runs only while `cmd_snt`=1, `resp_rdy`=0 and `resp_tmo`=0.
  - When it reaches `RESP_TMO`-1, `resp_tmo` sets and the counter stops.
  - `resp_tmo` is cleared by an accepted `snd_cmd`. It is not cleared by a late response; a late response still sets `resp_rdy`.
- **Counter width:** `$clog2(RESP_TMO)`, with no wrap-around.
- **Mid-operation reset:** aborts the frame. `TX` returns high immediately and no partial `cmd_snt` is produced.

## Timing
- `snd_cmd` is accepted at edge 0.
- `trmt` for the high byte is high during cycle 1.
- `trmt` for the low byte is high in the same cycle that the first `tx_done` is observed.
- `cmd_snt` rises on the edge after the second `tx_done` is observed.
- `busy` is high from edge 0 until that same edge.
- End-to-end latency is 2 × (10 × baud period) + 3 cycles, ±1 cycle of UART start alignment.
- `resp_rdy` rises on the edge after `rx_rdy` is seen. `resp` is valid whenever `resp_rdy`=1.
- Back-to-back commands are allowed: `snd_cmd` may be asserted in the first IDLE cycle after `cmd_snt` rises.

## Structure
- Sub-module: the existing `UART` transceiver (ports `clk`, `rst_n`, `RX`, `TX`, `rx_rdy`, `clr_rx_rdy`, `rx_data`, `trmt`, `tx_data`, `tx_done`), instantiated once.
- Shared package `comm_pkg`:
  - FSM state enum `rc_state_t`.
  - Default `RESP_TMO`.
  - Command-opcode constants, shared with the receiver-side command processor.
- Everything else (hold register, response register, flags, counter, FSM) lives in `remote_comm`.

## Test plan
- **Basic send:** loop `TX` back into a `UART_wrapper`. Send `cmd`=16'hA53C with a `snd_cmd` pulse -> wrapper `cmd`=16'hA53C with `cmd_rdy`=1, `remote_comm` `cmd_snt`=1, and `busy` falling on the same edge.
- **Busy protection:** mid-frame, pulse `snd_cmd` with `cmd`=16'hFFFF -> the transmitted word is still 16'hA53C and no extra frame appears on `TX`.
- **Response:** drive byte 8'hA5 into `RX` -> `resp`=8'hA5 and `resp_rdy`=1. Then pulse `clr_resp_rdy` -> `resp_rdy`=0 on the next edge. Assert `rx_rdy` and `clr_resp_rdy` in the same cycle -> `resp_rdy` stays 1.
- **Timeout:** with `RESP_TMO`=100, send a command with no response -> `resp_tmo` rises exactly 100 cycles after `cmd_snt`. A following `snd_cmd` clears `resp_tmo` and `cmd_snt`.
- **Reset mid-operation:** assert `rst_n`=0 during the high byte -> `TX`=1, `cmd_snt`=0 and `busy`=0 immediately. After release, send 16'h1234 -> it is received intact.
